// File: rtl/sumador_acumulador_sat_pkg.sv
// Shared types and constants for the saturating multiply-accumulate back-end.
// The saturation limits are produced wide and cut down to 2N bits by each user.
package sumador_acumulador_sat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACUM   = 2'd1,
        SALIDA = 2'd2
    } state_t;

    localparam int MAXW = 128;

    // Smallest GUARD that keeps bias plus TAPS products from wrapping the accumulator.
    function automatic int guard_min(input int taps);
        return $clog2(taps + 1);
    endfunction

    function automatic logic [MAXW-1:0] sat_max(input int w);
        return (MAXW'(1) << (w - 1)) - MAXW'(1);
    endfunction

    function automatic logic [MAXW-1:0] sat_min(input int w);
        return MAXW'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sumador_acumulador_sat_saturador.sv
// Clamps a guarded-width signed accumulator value to 2N bits and flags when
// the clamp was applied.
module sumador_acumulador_sat_saturador
    import sumador_acumulador_sat_pkg::*;
#(
    parameter int N     = 24,
    parameter int GUARD = 4
) (
    input  logic [2*N+GUARD-1:0] din,
    output logic [2*N-1:0]       dout,
    output logic                 desborde
);

    localparam int W = 2*N + GUARD;
    localparam logic [MAXW-1:0] MAX_FULL = sat_max(2*N);
    localparam logic [MAXW-1:0] MIN_FULL = sat_min(2*N);
    localparam logic [2*N-1:0]  MAX_V    = MAX_FULL[2*N-1:0];
    localparam logic [2*N-1:0]  MIN_V    = MIN_FULL[2*N-1:0];

    // In range exactly when the guard bits and the 2N-bit sign bit all agree.
    logic [GUARD:0] top_bits;

    always_comb begin
        top_bits = din[W-1:2*N-1];
        desborde = !((&top_bits) || !(|top_bits));
        if (!desborde) begin
            dout = din[2*N-1:0];
        end else if (din[W-1]) begin
            dout = MIN_V;
        end else begin
            dout = MAX_V;
        end
    end

endmodule

// File: rtl/sumador_acumulador_sat.sv
// Registered saturating multiply-accumulate: bias plus TAPS signed products per
// frame, one clamped result per frame with a valid pulse and an overflow flag.
module sumador_acumulador_sat
    import sumador_acumulador_sat_pkg::*;
#(
    parameter int N     = 24,
    parameter int TAPS  = 8,
    parameter int GUARD = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] Sum_ext,
    input  logic           prod_valid,
    input  logic [2*N-1:0] Multiplica,
    output logic [2*N-1:0] Suma_G,
    output logic           suma_valid,
    output logic           desborde,
    output logic           ocupado
);

    localparam int W  = 2*N + GUARD;
    localparam int CW = $clog2(TAPS) + 1;

    if (GUARD < guard_min(TAPS)) begin : g_guard_chk
        $error("GUARD too small: accumulator could wrap for this TAPS");
    end

    state_t          state, state_nx;
    logic [W-1:0]    acc, acc_nx;
    logic [CW-1:0]   count, count_nx;
    logic            load_out;
    logic [2*N-1:0]  sat_val;
    logic            sat_ovf;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        load_out = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nx   = {{GUARD{Sum_ext[2*N-1]}}, Sum_ext};
                    count_nx = '0;
                    state_nx = ACUM;
                end
            end
            ACUM: begin
                if (start) begin
                    acc_nx   = {{GUARD{Sum_ext[2*N-1]}}, Sum_ext};
                    count_nx = '0;
                end else if (prod_valid) begin
                    acc_nx = acc + {{GUARD{Multiplica[2*N-1]}}, Multiplica};
                    // Wrap the tap count on the last product so it never passes TAPS-1.
                    if (count == CW'(TAPS - 1)) begin
                        count_nx = '0;
                        state_nx = SALIDA;
                    end else begin
                        count_nx = count + CW'(1);
                    end
                end
            end
            SALIDA: begin
                load_out = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    sumador_acumulador_sat_saturador #(
        .N     (N),
        .GUARD (GUARD)
    ) u_saturador (
        .din      (acc),
        .dout     (sat_val),
        .desborde (sat_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            Suma_G     <= '0;
            suma_valid <= 1'b0;
            desborde   <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            count      <= count_nx;
            suma_valid <= load_out;
            if (load_out) begin
                Suma_G   <= sat_val;
                desborde <= sat_ovf;
            end
        end
    end

    assign ocupado = (state != IDLE);

endmodule

// File: tb/tb_sumador_acumulador_sat.sv
// Bench for sumador_acumulador_sat: frame vector table, directed restart/reset
// sequences and random frames against a plain-arithmetic frame model.
module tb_sumador_acumulador_sat;

    localparam int N    = 24;
    localparam int TAPS = 8;
    localparam int W2   = 2*N;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W2-1:0] Sum_ext;
    logic          prod_valid;
    logic [W2-1:0] Multiplica;
    logic [W2-1:0] Suma_G;
    logic          suma_valid;
    logic          desborde;
    logic          ocupado;

    sumador_acumulador_sat #(.N(N), .TAPS(TAPS), .GUARD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Sum_ext    (Sum_ext),
        .prod_valid (prod_valid),
        .Multiplica (Multiplica),
        .Suma_G     (Suma_G),
        .suma_valid (suma_valid),
        .desborde   (desborde),
        .ocupado    (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    logic [W2:0] exp_q[$];
    logic [W2:0] mon_e;

    typedef struct {
        logic [W2-1:0] bias;
        logic [W2-1:0] prod;
        int            max_bub;
        logic [W2-1:0] exp_sum;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W2-1:0] rand48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: return r[W2-1:0];
            1: return {{32{r[15]}}, r[15:0]};
            2: return 48'h7FFF_FFFF_FFFF - {44'd0, r[3:0]};
            default: return 48'h8000_0000_0000 + {44'd0, r[3:0]};
        endcase
    endfunction

    function automatic longint sx(input logic [W2-1:0] v);
        return longint'($signed(v));
    endfunction

    // Whole-frame reference: add everything in 64-bit arithmetic, then clamp.
    function automatic logic [W2:0] model(input longint bias, input longint p[$]);
        longint s;
        longint mx;
        longint mn;
        logic [63:0] u;
        s  = bias;
        foreach (p[i]) s += p[i];
        mx = (longint'(1) <<< (W2 - 1)) - 1;
        mn = -(longint'(1) <<< (W2 - 1));
        if (s > mx) return {1'b1, 48'h7FFF_FFFF_FFFF};
        if (s < mn) return {1'b1, 48'h8000_0000_0000};
        u = s;
        return {1'b0, u[W2-1:0]};
    endfunction

    // Scoreboard: every result pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && suma_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(suma_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("suma_g", 64'(Suma_G), 64'(mon_e[W2-1:0]));
                check("desborde", 64'(desborde), 64'(mon_e[W2]));
            end
        end
    end

    // Constant-product frame with exact latency checks around the result pulse.
    task automatic run_frame(input logic [W2-1:0] bias, input logic [W2-1:0] prod,
                             input int max_bub);
        start = 1'b1; Sum_ext = bias; prod_valid = 1'b0;
        step();
        start = 1'b0; Sum_ext = rand48();
        for (int i = 0; i < TAPS; i++) begin
            repeat ($urandom_range(0, max_bub)) begin
                prod_valid = 1'b0; Multiplica = rand48();
                step();
            end
            prod_valid = 1'b1; Multiplica = prod;
            step();
        end
        prod_valid = 1'b0;
        @(negedge clk);
        check("lat_early_valid", 64'(suma_valid), 64'd0);
        check("lat_ocupado_salida", 64'(ocupado), 64'd1);
        step();
        @(negedge clk);
        check("lat_valid", 64'(suma_valid), 64'd1);
        step();
        @(negedge clk);
        check("pulse_width", 64'(suma_valid), 64'd0);
        check("ocupado_after", 64'(ocupado), 64'd0);
    endtask

    task automatic random_frames(input int nframes);
        logic [W2-1:0] b;
        logic [W2-1:0] m;
        longint bias_m;
        longint prods[$];
        for (int f = 0; f < nframes; f++) begin
            b = rand48();
            start = 1'b1; Sum_ext = b; prod_valid = 1'($urandom_range(0, 1)); Multiplica = rand48();
            step();
            start = 1'b0;
            bias_m = sx(b);
            prods.delete();
            while (prods.size() < TAPS) begin
                if ($urandom_range(0, 19) == 0 && prods.size() > 0) begin
                    b = rand48();
                    start = 1'b1; Sum_ext = b; prod_valid = 1'b1; Multiplica = rand48();
                    step();
                    start = 1'b0;
                    bias_m = sx(b);
                    prods.delete();
                end else if ($urandom_range(0, 3) == 0) begin
                    prod_valid = 1'b0; Multiplica = rand48();
                    step();
                end else begin
                    m = rand48();
                    prod_valid = 1'b1; Multiplica = m;
                    step();
                    prods.push_back(sx(m));
                end
            end
            exp_q.push_back(model(bias_m, prods));
            prod_valid = 1'($urandom_range(0, 1)); Multiplica = rand48();
            step();
            repeat ($urandom_range(0, 2)) begin
                prod_valid = 1'($urandom_range(0, 1)); Multiplica = rand48();
                step();
            end
            prod_valid = 1'b0;
        end
    endtask

    initial begin
        int v0;
        reset = 1'b1; start = 1'b0; Sum_ext = '0; prod_valid = 1'b0; Multiplica = '0;

        vecs[0] = '{48'd10, 48'd5, 0, 48'd50, 1'b0};
        vecs[1] = '{48'd10, 48'd5, 3, 48'd50, 1'b0};
        vecs[2] = '{48'd0, 48'h4000_0000_0000, 1, 48'h7FFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{48'd0, 48'd1, 0, 48'd8, 1'b0};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 48'hC000_0000_0000, 2, 48'h8000_0000_0000, 1'b1};
        vecs[5] = '{48'h7FFF_FFFF_FFFF, 48'd0, 0, 48'h7FFF_FFFF_FFFF, 1'b0};
        vecs[6] = '{48'h8000_0000_0000, 48'd0, 0, 48'h8000_0000_0000, 1'b0};
        vecs[7] = '{48'h7FFF_FFFF_FFF8, 48'd1, 0, 48'h7FFF_FFFF_FFFF, 1'b1};
        vecs[8] = '{48'h8000_0000_0007, 48'hFFFF_FFFF_FFFF, 1, 48'h8000_0000_0000, 1'b1};

        step(); step();
        @(negedge clk);
        check("rst_suma_g", 64'(Suma_G), 64'd0);
        check("rst_valid", 64'(suma_valid), 64'd0);
        check("rst_desborde", 64'(desborde), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].exp_ovf, vecs[i].exp_sum});
            run_frame(vecs[i].bias, vecs[i].prod, vecs[i].max_bub);
        end

        // Restart mid-frame: the product presented with the second start is dropped.
        v0 = n_valid;
        exp_q.push_back({1'b0, 48'd9});
        start = 1'b1; Sum_ext = 48'd0; step();
        start = 1'b0;
        repeat (3) begin prod_valid = 1'b1; Multiplica = 48'd7; step(); end
        start = 1'b1; Sum_ext = 48'd1; prod_valid = 1'b1; Multiplica = 48'd100; step();
        start = 1'b0;
        repeat (TAPS) begin prod_valid = 1'b1; Multiplica = 48'd1; step(); end
        prod_valid = 1'b0;
        repeat (3) step();
        check("restart_single_valid", 64'(n_valid - v0), 64'd1);

        // Reset mid-frame discards the partial sum and clears the outputs.
        start = 1'b1; Sum_ext = 48'd0; step();
        start = 1'b0;
        repeat (4) begin prod_valid = 1'b1; Multiplica = 48'd3; step(); end
        prod_valid = 1'b0; reset = 1'b1;
        step();
        @(negedge clk);
        check("midrst_suma_g", 64'(Suma_G), 64'd0);
        check("midrst_valid", 64'(suma_valid), 64'd0);
        check("midrst_desborde", 64'(desborde), 64'd0);
        check("midrst_ocupado", 64'(ocupado), 64'd0);
        reset = 1'b0;
        v0 = n_valid;
        repeat (12) begin prod_valid = 1'b1; Multiplica = rand48(); step(); end
        prod_valid = 1'b0;
        step();
        check("idle_ignores_prod", 64'(n_valid - v0), 64'd0);
        check("idle_ocupado", 64'(ocupado), 64'd0);
        exp_q.push_back({1'b0, 48'd21});
        run_frame(48'd5, 48'd2, 0);

        random_frames(40);
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) step();
        check("drain_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
